flash_rom_arbiter: RTL and testbench
====================================

FLASH_ROM_ARBITER -- requirements
Module: flash_rom_arbiter

Interface
REQ-001 SHALL have parameter PRG_BASE, 24'h100000, flash byte address of PRG ROM image.
REQ-002 SHALL have parameter CHR_BASE, 24'h180000, flash byte address of CHR ROM image.
REQ-003 SHALL have parameter TIMEOUT, 4095, max cycles allowed between read issue and data return.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed below.
REQ-005 clk  input  1  sole clock, same clock as the flash controller.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 prg_req  input  1  PRG read request, level, held until prg_ack.
REQ-008 prg_addr  input  22  PRG byte offset, stable while prg_req high.
REQ-009 prg_ack  output  1  one-cycle pulse, prg_rdata valid.
REQ-010 prg_rdata  output  8  PRG read data, held until next prg_ack.
REQ-011 chr_req / chr_addr / chr_ack / chr_rdata  same directions and widths as PRG set, CHR port.
REQ-012 flash_ready  input  1  flash controller idle and able to accept a read.
REQ-013 flash_read_en  output  1  read command to flash controller.
REQ-014 flash_addr  output  24  flash byte address.
REQ-015 flash_rdata  input  8  byte returned by flash controller.
REQ-016 timeout_err  output  1  sticky flag, a flash read exceeded TIMEOUT.

Function
REQ-017 SHALL implement states IDLE, ISSUE, BUSY, RESP.
REQ-018 IDLE: a hit (REQ-024) SHALL go to RESP next cycle; otherwise, with flash_ready=1 and a pending request, SHALL latch the grant and address and go to ISSUE.
REQ-019 Arbitration when both requests are pending: round-robin, the port not granted last wins; after reset PRG wins.
REQ-020 flash_addr = base of granted port + zero-extended offset, modulo 2^24; SHALL be held stable from ISSUE through RESP.
REQ-021 ISSUE: flash_read_en=1 for exactly one cycle, then BUSY; flash_read_en SHALL be 0 in every other state.
REQ-022 BUSY: SHALL wait for flash_ready=1 on a cycle after ISSUE, capture flash_rdata on that cycle, then go to RESP.
REQ-023 RESP: ack of the granted port =1 for one cycle, rdata updated in the same cycle, then IDLE; the next request from the same port SHALL NOT be accepted before IDLE.
REQ-024 Per port, SHALL keep a one-entry buffer (last offset, data, valid bit); a request whose offset equals a valid entry is a hit and SHALL ack without a flash access (latency 2 cycles from req to ack).
REQ-025 Miss latency = 3 cycles + flash busy time; the ack for a miss SHALL fill the port's buffer.
REQ-026 BUSY SHALL count cycles with a 13-bit counter; at count == TIMEOUT SHALL set timeout_err, return 8'hFF, and go to RESP without filling the buffer.
REQ-027 A request that drops before its ack is a protocol violation; behaviour is undefined.

Reset
REQ-028 Asynchronous assertion SHALL force state IDLE, flash_read_en=0, flash_addr=0, both acks=0, both rdata=8'h00, buffers invalid, last-grant=CHR, counter=0, timeout_err=0.
REQ-029 Reset mid-transaction SHALL drop the pending request with no ack; the flash controller is reset by its own logic.
REQ-030 Deassertion SHALL be synchronised externally; the block SHALL act on the first clk edge after release.

Structure
REQ-031 State encoding and PRG/CHR port-index constants SHALL go in the shared package nes_flash_pkg.
REQ-032 The per-port buffer SHALL be one sub-module, rom_line_buf, instantiated twice.

Verification
REQ-033 Single PRG miss, prg_addr=22'h000010, flash model returns 8'hA5 after 12 busy cycles -> flash_addr=24'h100010, one read_en pulse, prg_ack with prg_rdata=8'hA5.
REQ-034 Repeat the same PRG address -> ack 2 cycles after req, no read_en.
REQ-035 PRG and CHR requested on the same cycle after reset -> PRG served first, then CHR at 24'h180000+offset; a second simultaneous pair -> CHR served first.
REQ-036 CHR offset 22'h3FFFFF with CHR_BASE=24'hF00000 -> flash_addr=24'h2FFFFF (wrap).
REQ-037 Flash model never re-asserts ready, TIMEOUT=20 -> ack after 20 BUSY cycles, rdata=8'hFF, timeout_err=1 until reset.
REQ-038 reset_n low during BUSY -> all outputs at reset values within the same cycle, no ack; a new request after release completes normally.

Source files
------------

// File: rtl/nes_flash_pkg.sv
// Shared types and constants for the NES flash ROM arbiter.
package nes_flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Port indices; also used as bit positions in per-port vectors.
    localparam logic PORT_PRG  = 1'b0;
    localparam logic PORT_CHR  = 1'b1;
    localparam int   NUM_PORTS = 2;

    localparam int OFF_W  = 22;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 13;

    // Flash byte address of a ROM offset; the sum wraps modulo 2^24.
    function automatic logic [ADDR_W-1:0] flash_byte_addr(input logic [ADDR_W-1:0] base,
                                                          input logic [OFF_W-1:0]  off);
        return base + {2'b00, off};
    endfunction

endpackage

// File: rtl/flash_rom_arbiter_if.sv
// Request/response bus between the PRG/CHR clients, the arbiter and the flash controller.
interface flash_rom_arbiter_if import nes_flash_pkg::*; ();

    logic              prg_req;
    logic [OFF_W-1:0]  prg_addr;
    logic              prg_ack;
    logic [DATA_W-1:0] prg_rdata;

    logic              chr_req;
    logic [OFF_W-1:0]  chr_addr;
    logic              chr_ack;
    logic [DATA_W-1:0] chr_rdata;

    logic              flash_ready;
    logic              flash_read_en;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_rdata;

    // Arbiter side.
    modport slave (
        input  prg_req, prg_addr, chr_req, chr_addr, flash_ready, flash_rdata,
        output prg_ack, prg_rdata, chr_ack, chr_rdata, flash_read_en, flash_addr
    );

    // Client and flash-controller side.
    modport master (
        output prg_req, prg_addr, chr_req, chr_addr, flash_ready, flash_rdata,
        input  prg_ack, prg_rdata, chr_ack, chr_rdata, flash_read_en, flash_addr
    );

endinterface

// File: rtl/rom_line_buf.sv
// One-entry read buffer: remembers the last offset fetched from flash and its byte.
module rom_line_buf import nes_flash_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_i,
    input  logic [OFF_W-1:0]  fill_addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic [OFF_W-1:0]  look_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [OFF_W-1:0]  addr_q;
    logic [DATA_W-1:0] data_q;

    // Replace the entry whenever a completed flash read is delivered to this port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr_i;
            data_q  <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (addr_q == look_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/flash_rom_arbiter.sv
// Round-robin arbiter sharing one flash controller between PRG and CHR ROM readers.
module flash_rom_arbiter import nes_flash_pkg::*; #(
    parameter logic [23:0] PRG_BASE = 24'h100000,
    parameter logic [23:0] CHR_BASE = 24'h180000,
    parameter int          TIMEOUT  = 4095
) (
    input  logic                 clk,
    input  logic                 reset_n,
    flash_rom_arbiter_if.slave   bus,
    output logic                 timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_e                         state_q;
    logic                               grant_q;
    logic                               last_q;
    logic [OFF_W-1:0]                   off_q;
    logic [ADDR_W-1:0]                  addr_q;
    logic                               read_en_q;
    logic [NUM_PORTS-1:0]               ack_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]                  data_q;
    logic                               fill_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic                               terr_q;

    logic [NUM_PORTS-1:0]               req_pend;
    logic [NUM_PORTS-1:0][OFF_W-1:0]    port_off;
    logic [NUM_PORTS-1:0]               buf_hit;
    logic [NUM_PORTS-1:0]               buf_fill;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   buf_data;
    logic                               pick_d;
    logic [ADDR_W-1:0]                  base_d;
    logic [CNT_W-1:0]                   cnt_d;

    assign port_off[PORT_PRG] = bus.prg_addr;
    assign port_off[PORT_CHR] = bus.chr_addr;

    // A port whose ack is on the bus this cycle still holds req; ignore it until IDLE sees it drop.
    assign req_pend = {bus.chr_req, bus.prg_req} & ~ack_q;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_buf
            assign buf_fill[gi] = (state_q == ST_RESP) && fill_q && (grant_q == 1'(gi));

            rom_line_buf u_buf (
                .clk         (clk),
                .rst_n       (reset_n),
                .fill_i      (buf_fill[gi]),
                .fill_addr_i (off_q),
                .fill_data_i (data_q),
                .look_addr_i (port_off[gi]),
                .hit_o       (buf_hit[gi]),
                .data_o      (buf_data[gi])
            );
        end
    endgenerate

    // Arbitration: on contention the port not granted last wins.
    always_comb begin
        pick_d = PORT_PRG;
        if (&req_pend) begin
            pick_d = ~last_q;
        end else if (req_pend[PORT_CHR]) begin
            pick_d = PORT_CHR;
        end
        base_d = (pick_d == PORT_CHR) ? CHR_BASE : PRG_BASE;
        cnt_d  = cnt_q + 13'd1;
    end

    // Main FSM; every bus output is a register written here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= PORT_PRG;
            last_q    <= PORT_CHR;
            off_q     <= '0;
            addr_q    <= '0;
            read_en_q <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            data_q    <= '0;
            fill_q    <= 1'b0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            read_en_q <= 1'b0;
            ack_q     <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_pend) begin
                        if (buf_hit[pick_d]) begin
                            grant_q <= pick_d;
                            last_q  <= pick_d;
                            off_q   <= port_off[pick_d];
                            data_q  <= buf_data[pick_d];
                            fill_q  <= 1'b0;
                            state_q <= ST_RESP;
                        end else if (bus.flash_ready) begin
                            grant_q   <= pick_d;
                            last_q    <= pick_d;
                            off_q     <= port_off[pick_d];
                            addr_q    <= flash_byte_addr(base_d, port_off[pick_d]);
                            read_en_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.flash_ready) begin
                        data_q  <= bus.flash_rdata;
                        fill_q  <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (cnt_d == TIMEOUT_CNT) begin
                        // Give up: the port gets 8'hFF and the buffer is left untouched.
                        terr_q  <= 1'b1;
                        data_q  <= 8'hFF;
                        fill_q  <= 1'b0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    ack_q[grant_q]   <= 1'b1;
                    rdata_q[grant_q] <= data_q;
                    state_q          <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.prg_ack       = ack_q[PORT_PRG];
    assign bus.prg_rdata     = rdata_q[PORT_PRG];
    assign bus.chr_ack       = ack_q[PORT_CHR];
    assign bus.chr_rdata     = rdata_q[PORT_CHR];
    assign bus.flash_read_en = read_en_q;
    assign bus.flash_addr    = addr_q;
    assign timeout_err       = terr_q;

endmodule

// File: tb/tb_flash_rom_arbiter.sv
// Scoreboard bench for flash_rom_arbiter with a behavioural flash controller.
module tb_flash_rom_arbiter;

    localparam logic [23:0] PRG_BASE = 24'h100000;
    localparam logic [23:0] CHR_BASE = 24'hF00000;
    localparam int          TIMEOUT  = 20;

    logic clk;
    logic reset_n;
    logic timeout_err;

    flash_rom_arbiter_if bus ();

    flash_rom_arbiter #(
        .PRG_BASE (PRG_BASE),
        .CHR_BASE (CHR_BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_fail      = 0;
    int read_en_cnt = 0;

    logic [7:0]  exp_prg_q[$];
    logic [7:0]  exp_chr_q[$];
    logic [23:0] exp_addr_q[$];
    logic [7:0]  resp_data_q[$];
    int          resp_delay_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_read(input logic [23:0] a, input logic [7:0] d, input int dly);
        exp_addr_q.push_back(a);
        resp_data_q.push_back(d);
        resp_delay_q.push_back(dly);
    endtask

    task automatic expect_ack(input bit is_chr, input logic [7:0] d);
        if (is_chr) exp_chr_q.push_back(d);
        else        exp_prg_q.push_back(d);
    endtask

    task automatic check_reset_values();
        check("rst_read_en",     32'(bus.flash_read_en), 32'd0);
        check("rst_flash_addr",  32'(bus.flash_addr),    32'd0);
        check("rst_prg_ack",     32'(bus.prg_ack),       32'd0);
        check("rst_chr_ack",     32'(bus.chr_ack),       32'd0);
        check("rst_prg_rdata",   32'(bus.prg_rdata),     32'd0);
        check("rst_chr_rdata",   32'(bus.chr_rdata),     32'd0);
        check("rst_timeout_err", 32'(timeout_err),       32'd0);
    endtask

    // Raise a request, wait (bounded) for its ack, drop it; optionally check req->ack latency.
    task automatic port_req(input bit is_chr, input logic [21:0] off, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        @(posedge clk);
        #1;
        if (is_chr) begin bus.chr_addr = off; bus.chr_req = 1'b1; end
        else        begin bus.prg_addr = off; bus.prg_req = 1'b1; end
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = is_chr ? bus.chr_ack : bus.prg_ack;
        end
        if (is_chr) bus.chr_req = 1'b0;
        else        bus.prg_req = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ack_wait: no ack within 300 cycles, required one", is_chr ? "chr" : "prg");
        end else if (exp_lat >= 0) begin
            check(is_chr ? "chr_latency" : "prg_latency", 32'(lat), 32'(exp_lat));
        end
    endtask

    // Flash controller model: drops ready after a read command, returns data after a set delay.
    initial begin : flash_model
        int          cnt;
        bit          busy;
        bit          prev_ren;
        logic [7:0]  pend_data;
        logic [23:0] cur_addr;
        cnt       = 0;
        busy      = 1'b0;
        prev_ren  = 1'b0;
        pend_data = 8'h00;
        cur_addr  = 24'h0;
        bus.flash_ready = 1'b1;
        bus.flash_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                busy            = 1'b0;
                prev_ren        = 1'b0;
                bus.flash_ready = 1'b1;
                bus.flash_rdata = 8'h00;
            end else begin
                if (bus.flash_read_en) begin
                    read_en_cnt++;
                    check("read_en_one_cycle", 32'(prev_ren), 32'd0);
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_read: flash_addr=%06h, required no read", bus.flash_addr);
                        cur_addr = bus.flash_addr;
                    end else begin
                        cur_addr = exp_addr_q.pop_front();
                        check("flash_addr", 32'(bus.flash_addr), 32'(cur_addr));
                    end
                    if (resp_delay_q.size() > 0) begin
                        cnt       = resp_delay_q.pop_front();
                        pend_data = resp_data_q.pop_front();
                    end else begin
                        cnt       = 2;
                        pend_data = 8'h00;
                    end
                    busy            = 1'b1;
                    bus.flash_ready = 1'b0;
                    bus.flash_rdata = 8'hEE;
                end else if (busy) begin
                    check("flash_addr_hold", 32'(bus.flash_addr), 32'(cur_addr));
                    if (cnt == 0) begin
                        busy            = 1'b0;
                        bus.flash_ready = 1'b1;
                        bus.flash_rdata = pend_data;
                    end else begin
                        cnt--;
                    end
                end
                prev_ren = bus.flash_read_en;
            end
        end
    end

    // Response monitor: every ack is matched against the port's expected-data queue.
    initial begin : ack_monitor
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (bus.prg_ack) begin
                    if (exp_prg_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL prg_unexpected_ack: rdata=%02h, required no ack", bus.prg_rdata);
                    end else begin
                        $display("txn PRG ack rdata=%02h", bus.prg_rdata);
                        check("prg_rdata", 32'(bus.prg_rdata), 32'(exp_prg_q.pop_front()));
                    end
                end
                if (bus.chr_ack) begin
                    if (exp_chr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL chr_unexpected_ack: rdata=%02h, required no ack", bus.chr_rdata);
                    end else begin
                        $display("txn CHR ack rdata=%02h", bus.chr_rdata);
                        check("chr_rdata", 32'(bus.chr_rdata), 32'(exp_chr_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r0;
        reset_n      = 1'b1;
        bus.prg_req  = 1'b0;
        bus.chr_req  = 1'b0;
        bus.prg_addr = '0;
        bus.chr_addr = '0;
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Simultaneous pair right after reset: PRG first (12-cycle flash), then CHR.
        expect_read(24'h100010, 8'hA5, 12);
        expect_read(24'hF00005, 8'hC3, 2);
        expect_ack(1'b0, 8'hA5);
        expect_ack(1'b1, 8'hC3);
        fork
            port_req(1'b0, 22'h000010, 16);
            port_req(1'b1, 22'h000005, -1);
        join
        check("terr_after_pair1", 32'(timeout_err), 32'd0);

        // Repeat PRG offset: buffer hit, 2-cycle latency, no flash read.
        r0 = read_en_cnt;
        expect_ack(1'b0, 8'hA5);
        port_req(1'b0, 22'h000010, 2);
        check("prg_hit_no_read", 32'(read_en_cnt - r0), 32'd0);

        // Second pair: PRG was granted last, so CHR goes first.
        expect_read(24'hF00040, 8'h22, 4);
        expect_read(24'h100030, 8'h11, 1);
        expect_ack(1'b1, 8'h22);
        expect_ack(1'b0, 8'h11);
        fork
            port_req(1'b1, 22'h000040, 8);
            port_req(1'b0, 22'h000030, -1);
        join

        // CHR hit on the refilled entry.
        r0 = read_en_cnt;
        expect_ack(1'b1, 8'h22);
        port_req(1'b1, 22'h000040, 2);
        check("chr_hit_no_read", 32'(read_en_cnt - r0), 32'd0);

        // CHR address wraps: F00000 + 3FFFFF = 2FFFFF mod 2^24.
        expect_read(24'h2FFFFF, 8'h77, 2);
        expect_ack(1'b1, 8'h77);
        port_req(1'b1, 22'h3FFFFF, 6);

        // PRG hit on the entry filled by the second pair.
        r0 = read_en_cnt;
        expect_ack(1'b0, 8'h11);
        port_req(1'b0, 22'h000030, 2);
        check("prg_hit2_no_read", 32'(read_en_cnt - r0), 32'd0);

        // Flash stays busy past TIMEOUT: ack after 20 BUSY cycles with 8'hFF.
        expect_read(24'h100100, 8'h5A, 40);
        expect_ack(1'b0, 8'hFF);
        port_req(1'b0, 22'h000100, 23);
        check("terr_set", 32'(timeout_err), 32'd1);

        // Same offset again must miss (timed-out data never filled the buffer).
        expect_read(24'h100100, 8'h6D, 3);
        expect_ack(1'b0, 8'h6D);
        port_req(1'b0, 22'h000100, -1);
        check("terr_sticky", 32'(timeout_err), 32'd1);

        // Reset while BUSY: outputs return to reset values immediately, no ack.
        r0 = read_en_cnt;
        expect_read(24'h100200, 8'h99, 30);
        @(posedge clk);
        #1;
        bus.prg_addr = 22'h000200;
        bus.prg_req  = 1'b1;
        repeat (6) @(posedge clk);
        check("read_before_reset", 32'(read_en_cnt - r0), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        bus.prg_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Buffers were cleared, so the old PRG offset is a miss again.
        expect_read(24'h100010, 8'h4B, 2);
        expect_ack(1'b0, 8'h4B);
        port_req(1'b0, 22'h000010, 6);
        check("terr_after_reset", 32'(timeout_err), 32'd0);

        repeat (2) @(negedge clk);
        check("prg_queue_drained",  32'(exp_prg_q.size()),  32'd0);
        check("chr_queue_drained",  32'(exp_chr_q.size()),  32'd0);
        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
